vga_vram_arbiter: RTL
=====================

Name: vga_vram_arbiter

Overview:
Shares one single-port synchronous video RAM between two users:
- the VGA display fetch, driven by the VGA sync core's counters;
- a CPU/bus requester using a req/ack handshake.
Display fetch has priority. The CPU gets free cycles, plus a forced slot under starvation. The block sits between the VGA sync core, the CPU bus bridge and the VRAM macro, all in the `clk` domain.

Parameters:
- ADDR_W, 19, VRAM word-address width.
- DATA_W, 12, pixel/data width (RGB 4:4:4).
- H_DISP, 640, visible pixels per line; also the address stride.
- V_DISP, 480, visible lines.
- STARVE_MAX, 8, consecutive display-won cycles with CPU pending before the CPU is forced in (range 2..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- pix_en  in  1  one-`clk` pulse per VGA pixel clock.
- vga_valid  in  1  sync core "visible area" flag.
- h_count  in  11  horizontal counter.
- v_count  in  11  vertical counter.
- disp_data  out  DATA_W  pixel to the DAC.
- disp_valid  out  1  pulse: disp_data updated.
- disp_underrun  out  1  pulse: pixel replaced by the previous pixel.
- cpu_req  in  1  CPU access request; held until ack.
- cpu_we  in  1  1 = write.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read data, valid when cpu_ack = 1.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data; valid the cycle after mem_en.

Behaviour:
- Reset (rst = 0, async):
  - FSM returns to ARB; starve_cnt = 0; display pipeline flags = 0.
  - disp_data, cpu_rdata = 0; disp_valid, disp_underrun, cpu_ack = 0.
  - mem_en, mem_we = 0 (combinational outputs gated by rst). mem_addr, mem_wdata = 0.
- Reset mid-access: an in-flight CPU access is dropped without ack. A write already presented to RAM may complete. The requester must re-issue.
- Display address: pix_addr = v_count*H_DISP + h_count, truncated to ADDR_W.
- Display slot: a "display slot" is a cycle with pix_en = 1 and in_range = 1, where in_range = vga_valid and h_count < H_DISP and v_count < V_DISP.
- Display fetch:
  - In a display slot: mem_en = 1, mem_we = 0, mem_addr = pix_addr (combinational, same cycle t).
  - In cycle t+1, mem_rdata is valid and is registered at the end of t+1.
  - disp_data and a disp_valid pulse appear in cycle t+2. Fixed latency: 2 clk.
- Blank pixels: pix_en = 1 with in_range = 0 issues no RAM access. disp_data = 0 and disp_valid pulses in cycle t+2 (same latency).
- FSM states: ARB, CPU_DATA, CPU_ACK.
  - ARB, display slot:
    - If cpu_req = 1 and starve_cnt = STARVE_MAX-1: CPU wins (see starvation rule).
    - Otherwise: display wins; starve_cnt increments if cpu_req = 1.
  - ARB, no display slot, cpu_req = 1: grant the CPU.
    - mem_en = 1, mem_we = cpu_we, mem_addr = cpu_addr, mem_wdata = cpu_wdata.
    - starve_cnt = 0; go to CPU_DATA.
  - CPU_DATA: capture mem_rdata into cpu_rdata (writes also capture it; value is don't-care). A display slot may use the port this cycle. Go to CPU_ACK.
  - CPU_ACK: cpu_ack = 1 for exactly one cycle. Display may use the port. No CPU grant this cycle. Go to ARB.
- CPU handshake:
  - CPU access latency: grant at t, ack at t+2.
  - The requester must keep cpu_req and its operands stable until ack, and deassert cpu_req (or present the next request) at the ack edge.
  - Back-to-back CPU accesses take a minimum of 3 cycles each.
- Starvation rule:
  - CPU takes the display slot; the display pixel is not fetched.
  - At t+2: disp_data holds its previous value, disp_valid = 1, disp_underrun = 1.
  - starve_cnt = 0.
- cpu_req = 0: starve_cnt holds its value.
- Simultaneous events: pix_en in CPU_DATA or CPU_ACK is always served by the display; no conflict, since the port is free.
- cpu_req while not in ARB: ignored until ARB.

Decomposition:
- Package vga_vram_pkg:
  - FSM state enum (ARB, CPU_DATA, CPU_ACK);
  - default H_DISP, V_DISP, ADDR_W, DATA_W constants.
- One sub-module, vga_pix_addr_gen:
  - computes in_range and pix_addr;
  - the multiply by the constant H_DISP is a shift-add (640 = 512 + 128).

Test Plan:
- Reset then idle, pix_en every 4 clk with (h,v) = (0,0),(1,0): mem_addr = 0, 1; VRAM preloaded 0xABC, 0x123 → disp_data = 0xABC, then 0x123, each exactly 2 clk after its pix_en; disp_valid pulses.
- CPU write addr 0x00100, data 0x5A5 in a non-pix_en cycle → mem_we = 1 that cycle, cpu_ack at t+2; then CPU read of 0x00100 → cpu_rdata = 0x5A5 with ack at t+2.
- pix_en coincident with cpu_req in ARB → display served (mem_addr = pix_addr, mem_we = 0); CPU granted on the next free cycle; ack 2 cycles after that grant.
- pix_en held high every clk, vga_valid = 1, cpu_req = 1 → CPU granted on the 8th contended cycle; disp_underrun = 1 and disp_data repeats the prior pixel 2 clk later; starve_cnt reads 0 afterwards.
- vga_valid = 0, or h_count = 700 with pix_en → no mem_en, disp_data = 0 at t+2.
- rst asserted in CPU_DATA → cpu_ack never pulses; all outputs 0 immediately; after release, a re-issued request is acked normally at t+2.

Source files
------------

// File: rtl/vga_vram_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : vga_vram_pkg
// Brief  : Shared FSM type and default display geometry for the VRAM arbiter.
// Rev    : 1.0
// ---------------------------------------------------------------------------
package vga_vram_pkg;

  localparam int c_addr_w = 19;
  localparam int c_data_w = 12;
  localparam int c_h_disp = 640;
  localparam int c_v_disp = 480;

  typedef enum logic [1:0] {
    ARB      = 2'd0,
    CPU_DATA = 2'd1,
    CPU_ACK  = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_pix_addr_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : vga_pix_addr_gen
// Brief  : Visible-area qualifier and linear VRAM address for the current pixel.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module vga_pix_addr_gen
  import vga_vram_pkg::*;
#(
  parameter int ADDR_W = c_addr_w,
  parameter int H_DISP = c_h_disp,
  parameter int V_DISP = c_v_disp
) (
  input  logic              vga_valid,
  input  logic [10:0]       h_count,
  input  logic [10:0]       v_count,
  output logic              in_range,
  output logic [ADDR_W-1:0] pix_addr
);

  localparam int          c_prod_w = (ADDR_W > 22) ? ADDR_W : 22;
  localparam logic [10:0] c_h_lim  = 11'(H_DISP);
  localparam logic [10:0] c_v_lim  = 11'(V_DISP);

  logic [c_prod_w-1:0] w_v_ext;
  logic [c_prod_w-1:0] w_row_base;
  logic [c_prod_w-1:0] w_sum;

  assign w_v_ext = c_prod_w'(v_count);

  // 640 = 512 + 128, so the row base is two shifted copies of v_count.
  generate
    if (H_DISP == 640) begin : g_shift_add
      assign w_row_base = (w_v_ext << 9) + (w_v_ext << 7);
    end else begin : g_mult
      assign w_row_base = w_v_ext * c_prod_w'(H_DISP);
    end
  endgenerate

  assign w_sum    = w_row_base + c_prod_w'(h_count);
  assign pix_addr = w_sum[ADDR_W-1:0];
  assign in_range = vga_valid && (h_count < c_h_lim) && (v_count < c_v_lim);

endmodule
`default_nettype wire

// File: rtl/vga_vram_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : vga_vram_arbiter
// Brief  : Shares one single-port VRAM between display fetch and a CPU port.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module vga_vram_arbiter
  import vga_vram_pkg::*;
#(
  parameter int ADDR_W     = c_addr_w,
  parameter int DATA_W     = c_data_w,
  parameter int H_DISP     = c_h_disp,
  parameter int V_DISP     = c_v_disp,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  input  logic              vga_valid,
  input  logic [10:0]       h_count,
  input  logic [10:0]       v_count,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              disp_underrun,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [7:0] c_starve_last = 8'(STARVE_MAX - 1);

  logic              w_in_range;
  logic [ADDR_W-1:0] w_pix_addr;
  logic              w_slot;
  logic              w_cpu_grant;
  logic              w_disp_fetch;

  arb_state_t        r_state;
  logic [7:0]        r_starve_cnt;
  logic              r_p1_valid;
  logic              r_p1_fetch;
  logic              r_p1_under;
  logic [DATA_W-1:0] r_disp_data;
  logic              r_disp_valid;
  logic              r_disp_underrun;
  logic              r_cpu_ack;
  logic [DATA_W-1:0] r_cpu_rdata;

  vga_pix_addr_gen #(
    .ADDR_W (ADDR_W),
    .H_DISP (H_DISP),
    .V_DISP (V_DISP)
  ) u_pix_addr_gen (
    .vga_valid (vga_valid),
    .h_count   (h_count),
    .v_count   (v_count),
    .in_range  (w_in_range),
    .pix_addr  (w_pix_addr)
  );

  assign w_slot       = pix_en & w_in_range;
  // The CPU only ever wins from ARB: on a free cycle, or by stealing a slot once starved.
  assign w_cpu_grant  = (r_state == ARB) & cpu_req & (~w_slot | (r_starve_cnt == c_starve_last));
  assign w_disp_fetch = w_slot & ~w_cpu_grant;

  assign mem_en = rst & (w_cpu_grant | w_disp_fetch);
  assign mem_we = rst & w_cpu_grant & cpu_we;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst && w_cpu_grant) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (rst && w_disp_fetch) begin
      mem_addr  = w_pix_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= ARB;
      r_starve_cnt    <= 8'd0;
      r_p1_valid      <= 1'b0;
      r_p1_fetch      <= 1'b0;
      r_p1_under      <= 1'b0;
      r_disp_data     <= '0;
      r_disp_valid    <= 1'b0;
      r_disp_underrun <= 1'b0;
      r_cpu_ack       <= 1'b0;
      r_cpu_rdata     <= '0;
    end else begin
      r_p1_valid      <= pix_en;
      r_p1_fetch      <= w_disp_fetch;
      r_p1_under      <= w_slot & w_cpu_grant;
      r_disp_valid    <= r_p1_valid;
      r_disp_underrun <= r_p1_under;
      // A stolen slot keeps the previous pixel; a blank pixel shows black.
      if (r_p1_fetch) begin
        r_disp_data <= mem_rdata;
      end else if (r_p1_valid && !r_p1_under) begin
        r_disp_data <= '0;
      end

      r_cpu_ack <= 1'b0;
      case (r_state)
        ARB: begin
          if (w_cpu_grant) begin
            r_state      <= CPU_DATA;
            r_starve_cnt <= 8'd0;
          end else if (w_disp_fetch && cpu_req) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
          end
        end
        CPU_DATA: begin
          r_cpu_rdata <= mem_rdata;
          r_cpu_ack   <= 1'b1;
          r_state     <= CPU_ACK;
        end
        CPU_ACK: r_state <= ARB;
        default: r_state <= ARB;
      endcase
    end
  end

  assign disp_data     = r_disp_data;
  assign disp_valid    = r_disp_valid;
  assign disp_underrun = r_disp_underrun;
  assign cpu_ack       = r_cpu_ack;
  assign cpu_rdata     = r_cpu_rdata;

endmodule
`default_nettype wire
